// File: rtl/shifter_mc_pkg.sv
// shifter_mc_pkg: shared state encoding, step size and ALU shift funct3 codes
// for the multi-cycle shifter.
package shifter_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int STEP = 4;

    localparam logic [2:0] SLL = 3'd1;
    localparam logic [2:0] SR_ = 3'd5;

endpackage

// File: rtl/shifter_mc.sv
// shifter_mc: iterative SLL/SRL/SRA unit that shifts STEP places per cycle while
// the remaining count allows, then single places, with RV64 word (w) support.
module shifter_mc
    import shifter_mc_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            kill,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            right,
    input  logic            ashr,
    input  logic            w,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [SHW-1:0] STEP_C = SHW'(STEP);

    state_e          state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            right_q, right_d;
    logic            ashr_q, ashr_d;
    logic            w_q, w_d;
    logic            w_eff;
    logic            fill;
    logic            big;
    logic [XLEN-1:0] load;
    logic            unused_op2;

    function automatic logic [XLEN-1:0] step_sh(input logic [XLEN-1:0] d, input logic r,
                                                input logic f, input logic b);
        logic [XLEN-1:0] l4, r4, l1, r1;
        l4 = {d[XLEN-STEP-1:0], {STEP{1'b0}}};
        r4 = {{STEP{f}}, d[XLEN-1:STEP]};
        l1 = {d[XLEN-2:0], 1'b0};
        r1 = {f, d[XLEN-1:1]};
        return b ? (r ? r4 : l4) : (r ? r1 : l1);
    endfunction

    assign w_eff      = (XLEN == 64) && w;
    assign fill       = right_q && ashr_q && data_q[XLEN-1];
    assign big        = cnt_q >= STEP_C;
    // Word right shifts pre-extend so the fill bit is already in the top position.
    assign load       = (right && w_eff) ? XLEN'($signed({ashr && op1[31], op1[31:0]})) : op1;
    assign unused_op2 = ^op2[XLEN-1:SHW];

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        right_d = right_q;
        ashr_d  = ashr_q;
        w_d     = w_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    state_d = BUSY;
                    data_d  = load;
                    cnt_d   = w_eff ? SHW'(op2[4:0]) : op2[SHW-1:0];
                    right_d = right;
                    ashr_d  = ashr;
                    w_d     = w_eff;
                end
                BUSY: if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    data_d = step_sh(data_q, right_q, fill, big);
                    cnt_d  = cnt_q - (big ? STEP_C : SHW'(1));
                end
                DONE: if (resp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            ashr_q  <= 1'b0;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            right_q <= right_d;
            ashr_q  <= ashr_d;
            w_q     <= w_d;
        end
    end

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == DONE;
    assign result     = w_q ? XLEN'($signed(data_q[31:0])) : data_q;

endmodule

// File: tb/tb_shifter_mc.sv
// tb_shifter_mc: directed and random checks of shifter_mc against an
// arithmetic reference model of results and BUSY timing.
module tb_shifter_mc;

    logic        clock = 0, reset = 0, kill = 0, req_valid = 0;
    logic        right = 0, ashr = 0, w = 0, resp_ready = 0;
    logic [63:0] op1 = '0, op2 = '0;
    logic        req_ready, resp_valid;
    logic [63:0] result;
    int          errors = 0, checks = 0;

    always #5 clock = ~clock;

    shifter_mc #(.XLEN(64)) dut (
        .clock(clock), .reset(reset), .kill(kill), .req_valid(req_valid),
        .req_ready(req_ready), .right(right), .ashr(ashr), .w(w), .op1(op1),
        .op2(op2), .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result)
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] ref_sh(bit r, bit a, bit ww, logic [63:0] x, logic [63:0] s);
        logic [31:0]        y32;
        logic signed [31:0] s32;
        logic [63:0]        y;
        logic signed [63:0] s64;
        int                 n;
        if (ww) begin
            n   = int'(s[4:0]);
            s32 = x[31:0];
            if (!r) y32 = x[31:0] << n;
            else if (a) y32 = s32 >>> n;
            else y32 = x[31:0] >> n;
            return {{32{y32[31]}}, y32};
        end
        n   = int'(s[5:0]);
        s64 = x;
        if (!r) y = x << n;
        else if (a) y = s64 >>> n;
        else y = x >> n;
        return y;
    endfunction

    typedef enum {M_IDLE, M_BUSY, M_DONE} mph_e;
    mph_e        m_ph = M_IDLE;
    int          m_left = 0, m_n = 0, m_acc_cnt = 0, dut_hs = 0;
    bit          m_acc = 0;
    logic [63:0] m_res = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ph  = M_IDLE;
            m_acc = 0;
        end else begin
            m_acc = 0;
            if (resp_valid && resp_ready) dut_hs++;
            if (kill) m_ph = M_IDLE;
            else case (m_ph)
                M_IDLE: if (req_valid) begin
                    m_n    = w ? int'(op2[4:0]) : int'(op2[5:0]);
                    m_left = m_n / 4 + m_n % 4 + 1;
                    m_res  = ref_sh(right, ashr, w, op1, op2);
                    m_ph   = M_BUSY;
                    m_acc  = 1;
                    m_acc_cnt++;
                end
                M_BUSY: begin
                    m_left--;
                    if (m_left == 0) m_ph = M_DONE;
                end
                M_DONE: if (resp_ready) m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
        end
    end

    always @(negedge clock) begin
        check("req_ready", 64'(req_ready), 64'(m_ph == M_IDLE));
        check("resp_valid", 64'(resp_valid), 64'(m_ph == M_DONE));
        if (m_ph == M_DONE) check("result", result, m_res);
        if (!reset) check("reset_result", result, 64'h0);
    end

    task automatic run_op(bit r, bit a, bit ww, logic [63:0] x, logic [63:0] s,
                          logic [63:0] exp, int exp_busy, int hold);
        int          busy;
        logic [63:0] held;
        right = r; ashr = a; w = ww; op1 = x; op2 = s;
        req_valid = 1; resp_ready = 0;
        @(posedge clock); #1;
        req_valid = 0;
        check("model_pin", ref_sh(r, a, ww, x, s), exp);
        busy = 0;
        while (!resp_valid && busy < 300) begin
            @(posedge clock); #1;
            busy++;
        end
        check("busy_cycles", 64'(busy), 64'(exp_busy));
        check("op_result", result, exp);
        repeat (hold) begin
            held = result;
            @(posedge clock); #1;
            check("hold_result", result, held);
            check("hold_req_ready", 64'(req_ready), 64'h0);
        end
        resp_ready = 1; req_valid = 1;
        @(posedge clock); #1;
        resp_ready = 0; req_valid = 0;
        check("resp_dropped", 64'(resp_valid), 64'h0);
        check("no_bypass", 64'(req_ready), 64'h1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_hs, bound, busy;
        repeat (3) @(posedge clock);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'h1);
        check("reset_resp_valid", 64'(resp_valid), 64'h0);
        reset = 1;
        @(posedge clock); #1;

        run_op(0, 0, 0, 64'h1, 64'd63, 64'h8000_0000_0000_0000, 19, 0);
        run_op(1, 1, 0, 64'hF000_0000_0000_0000, 64'd4, 64'hFF00_0000_0000_0000, 2, 0);
        run_op(1, 0, 0, 64'hF000_0000_0000_0000, 64'd4, 64'h0F00_0000_0000_0000, 2, 0);
        run_op(1, 1, 1, 64'h0000_0000_8000_0000, 64'h21, 64'hFFFF_FFFF_C000_0000, 2, 0);
        run_op(0, 0, 1, 64'h4000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 2, 0);
        run_op(0, 0, 0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h1234_5678_9ABC_DEF0, 1, 5);
        run_op(0, 0, 0, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFC7, 64'h6F_56DF_7780, 5, 0);
        run_op(1, 0, 1, 64'hFFFF_FFFF_8000_0010, 64'd4, 64'h0000_0000_0800_0001, 2, 0);
        run_op(1, 1, 0, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 19, 2);

        // kill in the middle of BUSY
        right = 0; ashr = 0; w = 0; op1 = 64'h5; op2 = 64'd63;
        req_valid = 1;
        @(posedge clock); #1;
        req_valid = 0;
        repeat (3) @(posedge clock);
        #1;
        kill = 1;
        @(posedge clock); #1;
        kill = 0;
        check("kill_busy_idle", 64'(req_ready), 64'h1);
        repeat (25) @(posedge clock);
        #1;
        check("kill_no_resp", 64'(resp_valid), 64'h0);

        // kill together with req_valid in IDLE
        kill = 1; req_valid = 1;
        @(posedge clock); #1;
        kill = 0; req_valid = 0;
        check("kill_wins", 64'(req_ready), 64'h1);

        // reset pulsed low in DONE
        op2 = 64'd0; req_valid = 1;
        @(posedge clock); #1;
        req_valid = 0;
        busy = 0;
        while (!resp_valid && busy < 50) begin
            @(posedge clock); #1;
            busy++;
        end
        check("pre_reset_done", 64'(resp_valid), 64'h1);
        #1 reset = 0;
        #1;
        check("async_reset_resp", 64'(resp_valid), 64'h0);
        check("async_reset_ready", 64'(req_ready), 64'h1);
        check("async_reset_result", result, 64'h0);
        @(negedge clock) reset = 1;
        @(posedge clock); #1;
        run_op(0, 0, 0, 64'hA5, 64'd8, 64'hA500, 3, 1);

        // random back-to-back traffic
        base_acc = m_acc_cnt;
        base_hs  = dut_hs;
        for (int i = 0; i < 2000; i++) begin
            right = 1'($urandom); ashr = 1'($urandom); w = 1'($urandom);
            op1 = {$urandom, $urandom};
            op2 = {$urandom, $urandom};
            if ((i % 4) == 0) op2[5:0] = 6'($urandom_range(0, 5));
            req_valid = 1;
            bound = 0;
            do begin
                resp_ready = 1'($urandom);
                @(posedge clock); #1;
                bound++;
            end while (!m_acc && bound < 200);
            if (bound >= 200) check("rand_accept_timeout", 64'(bound), 64'h0);
        end
        req_valid = 0; resp_ready = 1;
        bound = 0;
        while (m_ph != M_IDLE && bound < 200) begin
            @(posedge clock); #1;
            bound++;
        end
        resp_ready = 0;
        check("rand_drain", 64'(m_ph == M_IDLE), 64'h1);
        check("rand_resp_count", 64'(dut_hs - base_hs), 64'(m_acc_cnt - base_acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
